// File: rtl/program_loader_if.sv
// Host/CPU-facing bundle of the program loader: load handshake, control, status and instruction fetch port.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned INS_W  = 6
);
  logic              Start;
  logic [5:0]        LoadLen;
  logic              Abort;
  logic [INS_W-1:0]  InsIn;
  logic              InsValid;
  logic              InsReady;
  logic [ADDR_W-1:0] addr;
  logic [INS_W-1:0]  InsOut;
  logic              CPU_nReset;
  logic              Busy;
  logic              Done;
  logic              Err;

  modport master (
    output Start, LoadLen, Abort, InsIn, InsValid, addr,
    input  InsReady, InsOut, CPU_nReset, Busy, Done, Err
  );

  modport slave (
    input  Start, LoadLen, Abort, InsIn, InsValid, addr,
    output InsReady, InsOut, CPU_nReset, Busy, Done, Err
  );
endinterface

// File: rtl/program_loader.sv
// Loads a host-supplied program into a small register-file instruction memory and
// holds the CPU in reset until the load completes; fetch reads are combinational.
module program_loader #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned INS_W  = 6
) (
  input  logic            clk,
  input  logic            nReset,
  program_loader_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LEN_W = 6;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [1:0]        state_q, state_nxt;
  logic [ADDR_W-1:0] ptr_q, ptr_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic              err_q, err_nxt;
  logic              done_q, done_nxt;
  logic              ins_ready_q, busy_q, cpu_nreset_q;
  logic              wr_en;
  logic              start_ok;
  logic              last_word;
  logic [INS_W-1:0]  mem [DEPTH];

  assign start_ok  = (bus.LoadLen != '0) && (bus.LoadLen <= LEN_W'(DEPTH));
  assign last_word = (LEN_W'(ptr_q) == (len_q - LEN_W'(1)));

  // Next-state: Abort beats a same-cycle handshake; the pointer holds on the last word so it never wraps.
  always_comb begin
    state_nxt = state_q;
    ptr_nxt   = ptr_q;
    len_nxt   = len_q;
    err_nxt   = err_q;
    done_nxt  = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      LOAD: begin
        if (bus.Abort) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (bus.InsValid) begin
          wr_en = 1'b1;
          if (last_word) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end else begin
            ptr_nxt = ptr_q + ADDR_W'(1);
          end
        end
      end
      IDLE, RUN: begin
        if (bus.Start) begin
          if (start_ok) begin
            state_nxt = LOAD;
            ptr_nxt   = '0;
            len_nxt   = bus.LoadLen;
            err_nxt   = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      ins_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      cpu_nreset_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      ptr_q        <= ptr_nxt;
      len_q        <= len_nxt;
      err_q        <= err_nxt;
      done_q       <= done_nxt;
      ins_ready_q  <= (state_nxt == LOAD);
      busy_q       <= (state_nxt == LOAD);
      cpu_nreset_q <= (state_nxt == RUN);
    end
  end

  // Program storage survives reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (nReset && wr_en) begin
      mem[ptr_q] <= bus.InsIn;
    end
  end

  assign bus.InsOut     = mem[bus.addr];
  assign bus.InsReady   = ins_ready_q;
  assign bus.Busy       = busy_q;
  assign bus.CPU_nReset = cpu_nreset_q;
  assign bus.Done       = done_q;
  assign bus.Err        = err_q;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed vector table, hand-written corner
// sequences and a random run, all compared against a transaction-level reference model.
module tb_program_loader;
  logic clk;
  logic nReset;
  int   checks;
  int   errors;

  program_loader_if #(.ADDR_W(5), .INS_W(6)) bus ();

  program_loader #(.ADDR_W(5), .INS_W(6)) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 loading, 2 running; cnt = words already written this load.
  int         m_mode;
  int         m_cnt;
  int         m_len;
  logic       m_err;
  logic       m_done;
  logic [5:0] m_mem   [32];
  logic       m_known [32];

  typedef struct {
    logic       st;
    logic [5:0] ln;
    logic       ab;
    logic [5:0] ins;
    logic       vl;
    logic       e_ready;
    logic       e_done;
    logic       e_err;
    logic       e_cpu;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic st, input logic [5:0] ln,
                            input logic ab, input logic [5:0] ins, input logic vl);
    if (!rst) begin
      m_mode = 0; m_cnt = 0; m_len = 0; m_err = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_mode == 1) begin
        if (ab) begin
          m_mode = 0;
          m_err  = 1'b1;
        end else if (vl) begin
          m_mem[m_cnt]   = ins;
          m_known[m_cnt] = 1'b1;
          if (m_cnt + 1 == m_len) begin
            m_mode = 2;
            m_done = 1'b1;
          end else begin
            m_cnt++;
          end
        end
      end else if (st) begin
        if (ln >= 6'd1 && ln <= 6'd32) begin
          m_mode = 1; m_cnt = 0; m_len = int'(ln); m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  // One clock: drive, check read-before-write, advance, check all outputs against the model.
  task automatic step(input logic rst, input logic st, input logic [5:0] ln, input logic ab,
                      input logic [5:0] ins, input logic vl, input logic [4:0] ad);
    nReset       = rst;
    bus.Start    = st;
    bus.LoadLen  = ln;
    bus.Abort    = ab;
    bus.InsIn    = ins;
    bus.InsValid = vl;
    bus.addr     = ad;
    #1;
    if (m_known[ad]) chk("ins_out_pre", 32'(bus.InsOut), 32'(m_mem[ad]));
    model_edge(rst, st, ln, ab, ins, vl);
    @(posedge clk);
    #1;
    chk("ins_ready",  32'(bus.InsReady),   32'(m_mode == 1));
    chk("busy",       32'(bus.Busy),       32'(m_mode == 1));
    chk("cpu_nreset", 32'(bus.CPU_nReset), 32'(m_mode == 2));
    chk("done",       32'(bus.Done),       32'(m_done));
    chk("err",        32'(bus.Err),        32'(m_err));
    if (m_known[ad]) chk("ins_out", 32'(bus.InsOut), 32'(m_mem[ad]));
  endtask

  task automatic idle_step(input logic [4:0] ad);
    step(1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, ad);
  endtask

  task automatic peek(input string name, input logic [4:0] ad, input logic [5:0] exp);
    bus.addr = ad;
    #1;
    chk(name, 32'(bus.InsOut), 32'(exp));
  endtask

  int done_seen;

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 1'b0;
    end
    m_mode = 0; m_cnt = 0; m_len = 0; m_err = 1'b0; m_done = 1'b0;
    nReset = 1'b0; bus.Start = 1'b0; bus.LoadLen = '0; bus.Abort = 1'b0;
    bus.InsIn = '0; bus.InsValid = 1'b0; bus.addr = '0;

    // Reset state.
    @(posedge clk); #1;
    step(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 5'd0);
    chk("reset_cpu_nreset", 32'(bus.CPU_nReset), 32'd0);
    chk("reset_ready",      32'(bus.InsReady),   32'd0);

    // Three-word load with InsValid held high, then invalid Starts while running.
    tbl[0] = '{1'b1, 6'd3,  1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 6'd0,  1'b0, 6'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 6'd9,  1'b0, 6'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 6'd0,  1'b0, 6'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 6'd0,  1'b1, 6'h3f, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 6'd0,  1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 6'd40, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 6'd0,  1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, tbl[i].st, tbl[i].ln, tbl[i].ab, tbl[i].ins, tbl[i].vl, 5'(i % 3));
      chk($sformatf("tbl%0d_ready", i), 32'(bus.InsReady),   32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_done", i),  32'(bus.Done),       32'(tbl[i].e_done));
      chk($sformatf("tbl%0d_err", i),   32'(bus.Err),        32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_cpu", i),   32'(bus.CPU_nReset), 32'(tbl[i].e_cpu));
    end
    peek("word0", 5'd0, 6'h11);
    peek("word1", 5'd1, 6'h22);
    peek("word2", 5'd2, 6'h33);

    // Illegal lengths in IDLE set Err, leave memory alone; a legal Start clears Err.
    step(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 5'd0);
    step(1'b1, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0, 5'd1);
    chk("len0_err", 32'(bus.Err), 32'd1);
    step(1'b1, 1'b1, 6'd40, 1'b0, 6'h2a, 1'b1, 5'd2);
    chk("len40_ready", 32'(bus.InsReady), 32'd0);
    peek("len40_word2", 5'd2, 6'h33);
    step(1'b1, 1'b1, 6'd1, 1'b0, 6'd0, 1'b0, 5'd0);
    chk("err_cleared", 32'(bus.Err), 32'd0);
    step(1'b1, 1'b0, 6'd0, 1'b0, 6'h15, 1'b1, 5'd0);
    chk("len1_done", 32'(bus.Done), 32'd1);

    // Abort with a handshake on word 2 of a 5-word load.
    step(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 5'd0);
    step(1'b1, 1'b1, 6'd5, 1'b0, 6'd0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 6'd0, 1'b0, 6'h0a, 1'b1, 5'd0);
    step(1'b1, 1'b0, 6'd0, 1'b0, 6'h0b, 1'b1, 5'd1);
    step(1'b1, 1'b0, 6'd0, 1'b1, 6'h0c, 1'b1, 5'd2);
    chk("abort_err",  32'(bus.Err),        32'd1);
    chk("abort_cpu",  32'(bus.CPU_nReset), 32'd0);
    chk("abort_busy", 32'(bus.Busy),       32'd0);
    peek("abort_w0", 5'd0, 6'h0a);
    peek("abort_w1", 5'd1, 6'h0b);
    peek("abort_w2", 5'd2, 6'h33);
    step(1'b1, 1'b0, 6'd0, 1'b1, 6'h0d, 1'b1, 5'd3);

    // Reset in the middle of a load.
    step(1'b1, 1'b1, 6'd4, 1'b0, 6'd0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 6'd0, 1'b0, 6'h05, 1'b1, 5'd0);
    step(1'b1, 1'b0, 6'd0, 1'b0, 6'h06, 1'b1, 5'd1);
    step(1'b0, 1'b0, 6'd0, 1'b0, 6'h07, 1'b1, 5'd2);
    chk("midrst_busy", 32'(bus.Busy), 32'd0);
    chk("midrst_err",  32'(bus.Err),  32'd0);
    peek("midrst_w0", 5'd0, 6'h05);
    peek("midrst_w1", 5'd1, 6'h06);
    peek("midrst_w2", 5'd2, 6'h33);

    // Full 32-word load with InsValid every other cycle.
    done_seen = 0;
    step(1'b1, 1'b1, 6'd32, 1'b0, 6'd0, 1'b0, 5'd31);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b0, 6'd0, 1'b0, 6'((i / 2) ^ 6'h2a), 1'((i % 2) == 1), 5'd31);
      if (bus.Done) done_seen++;
    end
    for (int i = 0; i < 4; i++) begin
      idle_step(5'(i));
      if (bus.Done) done_seen++;
    end
    chk("len32_done_once", 32'(done_seen), 32'd1);
    chk("len32_running",   32'(bus.CPU_nReset), 32'd1);
    peek("len32_last", 5'd31, 6'(31 ^ 6'h2a));
    peek("len32_first", 5'd0, 6'h2a);

    // Reload from RUN: CPU reset drops immediately and rises together with Done.
    step(1'b1, 1'b1, 6'd2, 1'b0, 6'd0, 1'b0, 5'd0);
    chk("reload_cpu_low", 32'(bus.CPU_nReset), 32'd0);
    step(1'b1, 1'b1, 6'd7, 1'b0, 6'h31, 1'b1, 5'd0);
    step(1'b1, 1'b0, 6'd0, 1'b0, 6'h32, 1'b1, 5'd1);
    chk("reload_done", 32'(bus.Done),       32'd1);
    chk("reload_cpu",  32'(bus.CPU_nReset), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic       r_rst, r_st, r_ab, r_vl;
      logic [5:0] r_ln;
      r_rst = ($urandom_range(0, 199) != 0);
      r_st  = ($urandom_range(0, 7) == 0);
      r_ab  = ($urandom_range(0, 39) == 0);
      r_vl  = ($urandom_range(0, 2) != 0);
      r_ln  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(1, 32));
      step(r_rst, r_st, r_ln, r_ab, 6'($urandom_range(0, 63)), r_vl, 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
